// File: rtl/p405s_cr_write_sched.sv
// CR write-port scheduler: per-(source, field) pending-write counters, write-port arbitration and decode hazard hold.
// Optional APU producer is built in when P405S_CR_APU_EN is defined.
module p405s_cr_write_sched #(
    parameter int MAX_PEND = 3
) (
    input  logic       CB,
    input  logic       coreReset_Neg,
    input  logic       dcdIssue,
    input  logic [0:7] dcdCrRdMask,
    input  logic [0:7] dcdCrWrMask,
    input  logic [0:1] dcdCrWrSrc,
    input  logic       exeCrWrReq,
    input  logic       exe2CrWrReq,
    input  logic       apuCrWrReq,
    input  logic [0:7] exeCrWrMask,
    input  logic [0:7] exe2CrWrMask,
    input  logic [0:7] apuCrWrMask,
    input  logic       exeFlush,
    output logic [0:2] crWrGnt,
    output logic [0:7] crWrMask,
    output logic       dcdHoldForCr,
    output logic [0:7] crPendMask,
    output logic       crProtoErr
);
    localparam int CW = $clog2(MAX_PEND + 1);
    localparam int SRC_EXE = 0;
`ifdef P405S_CR_APU_EN
    localparam int NSRC = 3;
`else
    localparam int NSRC = 2;
`endif

    logic [CW-1:0] cnt_q [NSRC][8];
    logic [CW-1:0] cnt_d [NSRC][8];
    logic          proto_err_q, proto_err_d;
    logic [0:2]    gnt;
    logic [0:7]    gnt_mask;
    logic [0:7]    pend;
    logic          src_valid;
    logic          hazard;
    logic          issue_fire;
    int            src_idx;

`ifdef P405S_CR_APU_EN
    logic last_win_q, last_win_d;
    assign src_valid = (dcdCrWrSrc != 2'b11);
`else
    logic unused_apu;
    assign unused_apu = ^{apuCrWrReq, apuCrWrMask};
    assign src_valid  = (dcdCrWrSrc[0] == 1'b0);
`endif

    assign src_idx = int'(dcdCrWrSrc);

    // EXE has fixed priority; EXE2/APU alternate when both ask. Nothing is granted under reset.
    always_comb begin
        gnt      = 3'b000;
        gnt_mask = 8'h00;
        if (coreReset_Neg) begin
            if (exeCrWrReq && !exeFlush) begin
                gnt      = 3'b100;
                gnt_mask = exeCrWrMask;
            end
`ifdef P405S_CR_APU_EN
            else if (exe2CrWrReq && apuCrWrReq) begin
                if (last_win_q) begin
                    gnt      = 3'b010;
                    gnt_mask = exe2CrWrMask;
                end else begin
                    gnt      = 3'b001;
                    gnt_mask = apuCrWrMask;
                end
            end else if (apuCrWrReq) begin
                gnt      = 3'b001;
                gnt_mask = apuCrWrMask;
            end
`endif
            else if (exe2CrWrReq) begin
                gnt      = 3'b010;
                gnt_mask = exe2CrWrMask;
            end
        end
    end

    always_comb begin
        pend   = 8'h00;
        hazard = 1'b0;
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (cnt_q[s][f] != '0) begin
                    pend[f] = 1'b1;
                end
            end
        end
        for (int f = 0; f < 8; f++) begin
            if (dcdCrRdMask[f] && pend[f]) begin
                hazard = 1'b1;
            end
            if (dcdCrWrMask[f]) begin
                for (int s = 0; s < NSRC; s++) begin
                    if (s == src_idx) begin
                        if (cnt_q[s][f] == CW'(MAX_PEND)) begin
                            hazard = 1'b1;
                        end
                    end else if (cnt_q[s][f] != '0) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign dcdHoldForCr = dcdIssue & hazard;
    assign issue_fire   = dcdIssue & ~hazard & src_valid;

    // A same-cycle increment and decrement cancel; flush wipes EXE counters regardless of issue.
    always_comb begin
        proto_err_d = proto_err_q;
        if (dcdIssue && !src_valid) begin
            proto_err_d = 1'b1;
        end
        if ((gnt != 3'b000) && (gnt_mask == 8'h00)) begin
            proto_err_d = 1'b1;
        end
        for (int s = 0; s < NSRC; s++) begin
            for (int f = 0; f < 8; f++) begin
                cnt_d[s][f] = cnt_q[s][f];
                if (gnt[s] && gnt_mask[f] && (cnt_q[s][f] == '0)) begin
                    proto_err_d = 1'b1;
                end
                if (issue_fire && (s == src_idx) && dcdCrWrMask[f]) begin
                    if (!(gnt[s] && gnt_mask[f] && (cnt_q[s][f] != '0))) begin
                        cnt_d[s][f] = cnt_q[s][f] + CW'(1);
                    end
                end else if (gnt[s] && gnt_mask[f] && (cnt_q[s][f] != '0)) begin
                    cnt_d[s][f] = cnt_q[s][f] - CW'(1);
                end
                if ((s == SRC_EXE) && exeFlush) begin
                    cnt_d[s][f] = '0;
                end
            end
        end
    end

`ifdef P405S_CR_APU_EN
    always_comb begin
        last_win_d = last_win_q;
        if (gnt[1]) begin
            last_win_d = 1'b0;
        end else if (gnt[2]) begin
            last_win_d = 1'b1;
        end
    end

    always_ff @(posedge CB or negedge coreReset_Neg) begin
        if (!coreReset_Neg) begin
            last_win_q <= 1'b0;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`endif

    always_ff @(posedge CB or negedge coreReset_Neg) begin
        if (!coreReset_Neg) begin
            for (int s = 0; s < NSRC; s++) begin
                for (int f = 0; f < 8; f++) begin
                    cnt_q[s][f] <= '0;
                end
            end
            proto_err_q <= 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                for (int f = 0; f < 8; f++) begin
                    cnt_q[s][f] <= cnt_d[s][f];
                end
            end
            proto_err_q <= proto_err_d;
        end
    end

    assign crWrGnt    = gnt;
    assign crWrMask   = gnt_mask;
    assign crPendMask = pend;
    assign crProtoErr = proto_err_q;

endmodule

// File: tb/tb_p405s_cr_write_sched.sv
// Directed-vector bench for p405s_cr_write_sched; APU checks follow P405S_CR_APU_EN.
module tb_p405s_cr_write_sched;
    logic       CB = 1'b0;
    logic       coreReset_Neg = 1'b0;
    logic       dcdIssue = 1'b0;
    logic [0:7] dcdCrRdMask = 8'h00;
    logic [0:7] dcdCrWrMask = 8'h00;
    logic [0:1] dcdCrWrSrc = 2'b00;
    logic       exeCrWrReq = 1'b0;
    logic       exe2CrWrReq = 1'b0;
    logic       apuCrWrReq = 1'b0;
    logic [0:7] exeCrWrMask = 8'h00;
    logic [0:7] exe2CrWrMask = 8'h00;
    logic [0:7] apuCrWrMask = 8'h00;
    logic       exeFlush = 1'b0;
    logic [0:2] crWrGnt;
    logic [0:7] crWrMask;
    logic       dcdHoldForCr;
    logic [0:7] crPendMask;
    logic       crProtoErr;

    int compareCount = 0;
    int failCount = 0;

    p405s_cr_write_sched #(.MAX_PEND(3)) dut (
        .CB(CB),
        .coreReset_Neg(coreReset_Neg),
        .dcdIssue(dcdIssue),
        .dcdCrRdMask(dcdCrRdMask),
        .dcdCrWrMask(dcdCrWrMask),
        .dcdCrWrSrc(dcdCrWrSrc),
        .exeCrWrReq(exeCrWrReq),
        .exe2CrWrReq(exe2CrWrReq),
        .apuCrWrReq(apuCrWrReq),
        .exeCrWrMask(exeCrWrMask),
        .exe2CrWrMask(exe2CrWrMask),
        .apuCrWrMask(apuCrWrMask),
        .exeFlush(exeFlush),
        .crWrGnt(crWrGnt),
        .crWrMask(crWrMask),
        .dcdHoldForCr(dcdHoldForCr),
        .crPendMask(crPendMask),
        .crProtoErr(crProtoErr)
    );

    always #5 CB = ~CB;

    typedef struct {
        logic       issue;
        logic [7:0] rd;
        logic [7:0] wr;
        logic [1:0] src;
        logic       exe_req;
        logic [7:0] exe_mask;
        logic       exe2_req;
        logic [7:0] exe2_mask;
        logic       flush;
        logic [2:0] gnt;
        logic [7:0] mask;
        logic       hold;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic issue, input logic [7:0] rd, input logic [7:0] wr,
                                   input logic [1:0] src, input logic exe_req, input logic [7:0] exe_mask,
                                   input logic exe2_req, input logic [7:0] exe2_mask, input logic flush,
                                   input logic [2:0] gnt, input logic [7:0] mask, input logic hold,
                                   input logic [7:0] pend);
        vec_t v;
        v.issue = issue; v.rd = rd; v.wr = wr; v.src = src;
        v.exe_req = exe_req; v.exe_mask = exe_mask;
        v.exe2_req = exe2_req; v.exe2_mask = exe2_mask; v.flush = flush;
        v.gnt = gnt; v.mask = mask; v.hold = hold; v.pend = pend;
        return v;
    endfunction

    task automatic clearInputs();
        dcdIssue = 1'b0; dcdCrRdMask = 8'h00; dcdCrWrMask = 8'h00; dcdCrWrSrc = 2'b00;
        exeCrWrReq = 1'b0; exe2CrWrReq = 1'b0; apuCrWrReq = 1'b0;
        exeCrWrMask = 8'h00; exe2CrWrMask = 8'h00; apuCrWrMask = 8'h00;
        exeFlush = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        dcdIssue = v.issue; dcdCrRdMask = v.rd; dcdCrWrMask = v.wr; dcdCrWrSrc = v.src;
        exeCrWrReq = v.exe_req; exeCrWrMask = v.exe_mask;
        exe2CrWrReq = v.exe2_req; exe2CrWrMask = v.exe2_mask;
        apuCrWrReq = 1'b0; apuCrWrMask = 8'h00;
        exeFlush = v.flush;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkGnt(input string name, input logic [2:0] gnt, input logic [7:0] mask);
        checkOutput({name, " gnt"}, {5'b0, crWrGnt}, {5'b0, gnt});
        checkOutput({name, " mask"}, crWrMask, mask);
    endtask

    task automatic resetPulse();
        @(negedge CB);
        clearInputs();
        coreReset_Neg = 1'b0;
        #2;
        coreReset_Neg = 1'b1;
    endtask

    task automatic issueOne(input logic [7:0] wr, input logic [1:0] src);
        @(negedge CB);
        clearInputs();
        dcdIssue = 1'b1; dcdCrWrMask = wr; dcdCrWrSrc = src;
        #1;
        checkOutput("issue hold", {7'b0, dcdHoldForCr}, 8'h00);
    endtask

    initial begin
        // Field 0 is 8'h80, field 7 is 8'h01; grants encode {EXE, EXE2, APU}.
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h80, 2'd1, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h80, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1, 8'h80));
        vecs.push_back(mkVec(1, 8'h80, 8'h00, 2'd0, 0, 8'h00, 1, 8'h80, 0, 3'b010, 8'h80, 1, 8'h80));
        vecs.push_back(mkVec(1, 8'h80, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h30, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h30, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h30));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd1, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h30));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd1, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h31));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 1, 8'h30, 1, 8'h01, 0, 3'b100, 8'h30, 0, 8'h31));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 1, 8'h30, 1, 8'h01, 0, 3'b100, 8'h30, 0, 8'h31));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 1, 8'h01, 0, 3'b010, 8'h01, 0, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 0, 8'h00, 1, 8'h01, 0, 3'b010, 8'h01, 1, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 1, 8'h01, 0, 8'h00, 0, 3'b100, 8'h01, 1, 8'h01));
        vecs.push_back(mkVec(1, 8'h00, 8'h01, 2'd0, 1, 8'h01, 0, 8'h00, 0, 3'b100, 8'h01, 0, 8'h01));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 1, 8'h01, 0, 8'h00, 0, 3'b100, 8'h01, 0, 8'h01));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 1, 8'h01, 0, 8'h00, 0, 3'b100, 8'h01, 0, 8'h01));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h0C, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h0C, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h0C));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 1, 8'h0C, 0, 8'h00, 1, 3'b000, 8'h00, 0, 8'h0C));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h40, 2'd0, 0, 8'h00, 0, 8'h00, 1, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(1, 8'h00, 8'h02, 2'd1, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 1, 3'b000, 8'h00, 0, 8'h02));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 1, 8'h02, 0, 3'b010, 8'h02, 0, 8'h02));
        vecs.push_back(mkVec(0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 0, 8'h00));

        // Reset state, with an EXE request present to show no grant leaks out under reset.
        exeCrWrReq = 1'b1; exeCrWrMask = 8'h80;
        #1;
        checkGnt("reset", 3'b000, 8'h00);
        checkOutput("reset pend", crPendMask, 8'h00);
        checkOutput("reset hold", {7'b0, dcdHoldForCr}, 8'h00);
        checkOutput("reset err", {7'b0, crProtoErr}, 8'h00);
        clearInputs();
        @(negedge CB);
        coreReset_Neg = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CB);
            applyStimulus(vecs[i]);
            #1;
            checkGnt($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].mask);
            checkOutput($sformatf("vec%0d hold", i), {7'b0, dcdHoldForCr}, {7'b0, vecs[i].hold});
            checkOutput($sformatf("vec%0d pend", i), crPendMask, vecs[i].pend);
            checkOutput($sformatf("vec%0d err", i), {7'b0, crProtoErr}, 8'h00);
        end

        // EXE2 grant with nothing pending: sticky error until reset.
        @(negedge CB);
        clearInputs();
        exe2CrWrReq = 1'b1; exe2CrWrMask = 8'h01;
        #1;
        checkGnt("stray exe2", 3'b010, 8'h01);
        @(negedge CB);
        clearInputs();
        #1;
        checkOutput("stray err set", {7'b0, crProtoErr}, 8'h01);
        repeat (3) @(negedge CB);
        checkOutput("stray err sticky", {7'b0, crProtoErr}, 8'h01);
        resetPulse();
        #1;
        checkOutput("stray err cleared", {7'b0, crProtoErr}, 8'h00);

        // A granted mask of zero is a protocol error.
        @(negedge CB);
        exeCrWrReq = 1'b1; exeCrWrMask = 8'h00;
        #1;
        checkGnt("zero mask", 3'b100, 8'h00);
        @(negedge CB);
        clearInputs();
        #1;
        checkOutput("zero mask err", {7'b0, crProtoErr}, 8'h01);
        resetPulse();

        // Illegal source 11 is ignored and flags an error.
        @(negedge CB);
        dcdIssue = 1'b1; dcdCrWrMask = 8'h80; dcdCrWrSrc = 2'b11;
        @(negedge CB);
        clearInputs();
        #1;
        checkOutput("src11 err", {7'b0, crProtoErr}, 8'h01);
        checkOutput("src11 pend", crPendMask, 8'h00);
        resetPulse();

        // Reset mid-operation drops pending state immediately, between clock edges.
        issueOne(8'h80, 2'd0);
        @(negedge CB);
        clearInputs();
        exeCrWrReq = 1'b1; exeCrWrMask = 8'h80;
        #1;
        checkOutput("midreset pend before", crPendMask, 8'h80);
        checkGnt("midreset before", 3'b100, 8'h80);
        coreReset_Neg = 1'b0;
        #1;
        checkOutput("midreset pend", crPendMask, 8'h00);
        checkGnt("midreset", 3'b000, 8'h00);
        clearInputs();
        #1;
        coreReset_Neg = 1'b1;
        @(negedge CB);
        #1;
        checkOutput("midreset err", {7'b0, crProtoErr}, 8'h00);

`ifdef P405S_CR_APU_EN
        // Pending: EXE field0 x3, EXE2 field1 x2, APU field2 x2.
        repeat (3) issueOne(8'h80, 2'd0);
        repeat (2) issueOne(8'h40, 2'd1);
        repeat (2) issueOne(8'h20, 2'd2);
        // A lone APU grant makes APU the last winner, so EXE2 is next in the tie.
        @(negedge CB);
        clearInputs();
        apuCrWrReq = 1'b1; apuCrWrMask = 8'h20;
        #1;
        checkGnt("apu alone", 3'b001, 8'h20);
        for (int i = 0; i < 3; i++) begin
            @(negedge CB);
            exeCrWrReq = 1'b1; exeCrWrMask = 8'h80;
            exe2CrWrReq = 1'b1; exe2CrWrMask = 8'h40;
            apuCrWrReq = 1'b1; apuCrWrMask = 8'h20;
            #1;
            checkGnt($sformatf("all req %0d", i), 3'b100, 8'h80);
        end
        @(negedge CB);
        exeCrWrReq = 1'b0;
        #1;
        checkGnt("alt 0", 3'b010, 8'h40);
        @(negedge CB);
        #1;
        checkGnt("alt 1", 3'b001, 8'h20);
        @(negedge CB);
        #1;
        checkGnt("alt 2", 3'b010, 8'h40);
        @(negedge CB);
        clearInputs();
        #1;
        checkOutput("alt pend", crPendMask, 8'h00);
        checkOutput("alt err", {7'b0, crProtoErr}, 8'h00);
`else
        // Without the APU, its request is ignored and source 10 is illegal.
        @(negedge CB);
        clearInputs();
        apuCrWrReq = 1'b1; apuCrWrMask = 8'h80;
        #1;
        checkGnt("apu ignored", 3'b000, 8'h00);
        @(negedge CB);
        clearInputs();
        #1;
        checkOutput("apu ignored err", {7'b0, crProtoErr}, 8'h00);
        dcdIssue = 1'b1; dcdCrWrMask = 8'h80; dcdCrWrSrc = 2'b10;
        @(negedge CB);
        clearInputs();
        #1;
        checkOutput("src10 err", {7'b0, crProtoErr}, 8'h01);
        checkOutput("src10 pend", crPendMask, 8'h00);
        // Counter for field 0 must still be zero: an EXE2 issue there is not held.
        dcdIssue = 1'b1; dcdCrWrMask = 8'h80; dcdCrWrSrc = 2'b01;
        #1;
        checkOutput("src10 no count", {7'b0, dcdHoldForCr}, 8'h00);
        @(negedge CB);
        clearInputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/p405s_cr_write_sched.md
# p405s_cr_write_sched

Scheduler for the condition-register write port. It records which CR fields each issued instruction will write, and from which producer: EXE, EXE2 (multi-cycle record forms) or APU. It grants the single CR write port to one producer per cycle and stalls decode on CR read-after-write, write-after-write or counter-overflow hazards. It sits between decode/PCL and the CR datapath; its grant and mask drive the CR register enables and field selects.

## Interface
Parameters:
- MAX_PEND, 3, maximum outstanding writes per (field, source) counter; counter width is clog2(MAX_PEND+1)

Ports:
- CB  in  1  core clock, posedge
- coreReset_Neg  in  1  asynchronous active-low reset
- dcdIssue  in  1  decode issues an instruction this cycle
- dcdCrRdMask  in  [0:7]  CR fields read by the issuing instruction
- dcdCrWrMask  in  [0:7]  CR fields written by the issuing instruction
- dcdCrWrSrc  in  [0:1]  producer of those writes: 00 EXE, 01 EXE2, 10 APU, 11 illegal
- exeCrWrReq / exe2CrWrReq / apuCrWrReq  in  1 each  producer requests the write port
- exeCrWrMask / exe2CrWrMask / apuCrWrMask  in  [0:7] each  fields the request writes
- exeFlush  in  1  EXE-stage flush
- crWrGnt  out  [0:2]  one-hot grant {EXE, EXE2, APU}; 000 means no write
- crWrMask  out  [0:7]  mask of the granted requester; 0 when no grant
- dcdHoldForCr  out  1  decode must not issue
- crPendMask  out  [0:7]  field has any nonzero counter
- crProtoErr  out  1  sticky protocol error

## Operation
- State: counters cnt[src][field] for src in {EXE, EXE2, APU} and 8 fields; a 1-bit lastWin flag for EXE2/APU (0 = EXE2 won last); the crProtoErr flop.
- Arbitration, one grant per cycle:
  - EXE, gated by ~exeFlush, has fixed highest priority.
  - Otherwise, if EXE2 and APU both request, the one that did not win last is granted.
  - lastWin updates only on an EXE2 or APU grant.
- A requester that is not granted keeps its request and mask stable until it is granted.
- On a grant: cnt[src][f] decrements for every f set in the granted mask.
- Issue takes effect only when dcdIssue=1, dcdHoldForCr=0 and dcdCrWrSrc!=11. Then cnt[dcdCrWrSrc][f] increments for every f set in dcdCrWrMask.
- Grant decrement and issue increment on the same counter in the same cycle leave it unchanged.
- dcdHoldForCr = dcdIssue & any of:
  - dcdCrRdMask overlaps crPendMask;
  - dcdCrWrMask overlaps a field with a nonzero counter of a different source;
  - any targeted cnt[dcdCrWrSrc][f] equals MAX_PEND.
- exeFlush: all EXE counters clear to 0 at the next edge, overriding any same-cycle EXE increment. Other sources are unaffected.
- crProtoErr sets, and stays set until reset, on any of:
  - a grant whose mask includes a field with a zero counter for that source;
  - an issue attempt with dcdCrWrSrc=11;
  - a granted mask of 0.

## Timing
- Reset (asynchronous, coreReset_Neg low): all counters 0, lastWin=0, crProtoErr=0. Outputs then read crWrGnt=000, crWrMask=0, crPendMask=0, dcdHoldForCr=0.
- crWrGnt, crWrMask and dcdHoldForCr are combinational from current inputs and registered state, with zero latency.
- crPendMask is derived from registered counters only.
- Counter, lastWin and crProtoErr updates become visible the cycle after the edge.
- Hazard checks use pre-edge counts. A field whose last pending write is granted in cycle N still holds a same-cycle reader in N; that reader issues in N+1.
- Reset asserted mid-operation drops all pending state immediately. No grant is issued while reset is asserted.

## Configuration
- P405S_CR_APU_EN defined:
  - APU source, APU counters and the EXE2/APU alternation are present as described.
- Not defined:
  - apuCrWrReq and apuCrWrMask are ignored; crWrGnt[2]=0 always.
  - No APU counters or lastWin flop; EXE2 is granted whenever EXE is not.
  - dcdCrWrSrc=10 is treated as illegal: it is ignored and sets crProtoErr.

## Test plan
- Reset, then issue a write to field 0 from EXE2 and a read of field 0 in the next cycle:
  - crPendMask=8'h80 and dcdHoldForCr=1;
  - after exe2CrWrReq with mask 8'h80 is granted (crWrGnt=010), the hold drops the following cycle.
- EXE, EXE2 and APU request together for 3 consecutive cycles, with enough pending writes for every grant:
  - grants are 100, 100, 100;
  - drop the EXE request, then grants alternate 010, 001, 010.
- Three EXE issues to field 7 without grants: the fourth issue sees dcdHoldForCr=1 (count = MAX_PEND=3).
- Two EXE issues to mask 8'h0C, then exeFlush: next cycle crPendMask=0, and an EXE request during the flush receives no grant.
- EXE2 grant with mask 8'h01 while no EXE2 write is pending: crProtoErr=1 and stays 1 until coreReset_Neg pulses low.
- Build without P405S_CR_APU_EN: apuCrWrReq=1 alone gives crWrGnt=000; an issue with dcdCrWrSrc=10 sets crProtoErr and leaves all counters at 0.
